// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants: opcodes and functs (shared with the control unit),
// the symbolic loader op enumeration, loader error codes and loader states.
package mips_isa_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR  = 6'h08;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLT  = 4'd2,
    OP_JR   = 4'd3,
    OP_ADDI = 4'd4,
    OP_SLTI = 4'd5,
    OP_LW   = 4'd6,
    OP_SW   = 4'd7,
    OP_J    = 4'd8,
    OP_JAL  = 4'd9,
    OP_BEQ  = 4'd10,
    OP_BNE  = 4'd11,
    OP_NOP  = 4'd12
  } inst_op_e;

  typedef enum logic [1:0] {
    ERR_ILLEGAL_OP   = 2'd0,
    ERR_MISALIGNED   = 2'd1,
    ERR_BRANCH_RANGE = 2'd2,
    ERR_JUMP_REGION  = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } enc_state_e;

endpackage

// File: rtl/mips_field_pack.sv
// Combinational packer: turns a symbolic op plus already-resolved fields into
// a 32-bit MIPS word, flagging op codes that have no encoding.
module mips_field_pack
  import mips_isa_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [15:0] br_off_i,
  input  logic [25:0] j_field_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = 32'h0;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADD:  word_o = {OPC_RTYPE, rs_i, rt_i, rd_i, 5'b0, FUNCT_ADD};
      OP_SUB:  word_o = {OPC_RTYPE, rs_i, rt_i, rd_i, 5'b0, FUNCT_SUB};
      OP_SLT:  word_o = {OPC_RTYPE, rs_i, rt_i, rd_i, 5'b0, FUNCT_SLT};
      OP_JR:   word_o = {OPC_RTYPE, rs_i, 15'b0, FUNCT_JR};
      OP_ADDI: word_o = {OPC_ADDI, rs_i, rt_i, imm_i};
      OP_SLTI: word_o = {OPC_SLTI, rs_i, rt_i, imm_i};
      OP_LW:   word_o = {OPC_LW, rs_i, rt_i, imm_i};
      OP_SW:   word_o = {OPC_SW, rs_i, rt_i, imm_i};
      OP_J:    word_o = {OPC_J, j_field_i};
      OP_JAL:  word_o = {OPC_JAL, j_field_i};
      OP_BEQ:  word_o = {OPC_BEQ, rs_i, rt_i, br_off_i};
      OP_BNE:  word_o = {OPC_BNE, rs_i, rt_i, br_off_i};
      OP_NOP:  word_o = 32'h0;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_inst_encoder.sv
// Sequential instruction loader: assembles symbolic instructions, resolves
// branch/jump targets against its running address and streams words to memory.
module mips_inst_encoder
  import mips_isa_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  in_op_i,
  input  logic [4:0]  in_rs_i,
  input  logic [4:0]  in_rt_i,
  input  logic [4:0]  in_rd_i,
  input  logic [15:0] in_imm_i,
  input  logic [31:0] in_target_i,
  input  logic        in_last_i,
  output logic        wr_valid_o,
  input  logic        wr_ready_i,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic [8:0]  count_o,
  output logic        busy_o,
  output logic        full_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  enc_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [8:0]  count_q, count_d;
  logic        wr_valid_q, wr_valid_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        err_q, err_d;
  err_code_e   err_code_q, err_code_d;

  logic [9:0]         committed;
  logic               full;
  logic               in_ready;
  logic               accept;
  logic               handshake;
  logic [31:0]        next_pc;
  logic [31:0]        br_diff;
  logic signed [31:0] br_off;
  logic               br_in_range;
  logic               is_branch;
  logic               is_jump;
  logic               misaligned;
  logic               region_ok;
  logic [31:0]        packed_word;
  logic               illegal;
  logic               acc_err;
  err_code_e          acc_code;

  // A word sitting in the output stage already consumes a slot of capacity.
  assign committed = {1'b0, count_q} + {9'b0, wr_valid_q};
  assign full      = (committed == 10'(MAX_WORDS));
  assign in_ready  = (state_q == ST_RUN) && !full && (!wr_valid_q || wr_ready_i);
  assign accept    = in_valid_i && in_ready && !start_i;
  assign handshake = wr_valid_q && wr_ready_i;

  assign next_pc     = addr_q + 32'd4;
  assign br_diff     = in_target_i - next_pc;
  assign br_off      = $signed(br_diff) >>> 2;
  assign br_in_range = (br_off >= -32'sd32768) && (br_off <= 32'sd32767);
  assign is_branch   = (in_op_i == OP_BEQ) || (in_op_i == OP_BNE);
  assign is_jump     = (in_op_i == OP_J) || (in_op_i == OP_JAL);
  assign misaligned  = (in_target_i[1:0] != 2'b00);
  assign region_ok   = (in_target_i[31:28] == next_pc[31:28]);

  mips_field_pack u_pack (
    .op_i      (in_op_i),
    .rs_i      (in_rs_i),
    .rt_i      (in_rt_i),
    .rd_i      (in_rd_i),
    .imm_i     (in_imm_i),
    .br_off_i  (br_off[15:0]),
    .j_field_i (in_target_i[27:2]),
    .word_o    (packed_word),
    .illegal_o (illegal)
  );

  always_comb begin
    acc_err  = 1'b1;
    acc_code = ERR_ILLEGAL_OP;
    if (illegal) begin
      acc_code = ERR_ILLEGAL_OP;
    end else if ((is_branch || is_jump) && misaligned) begin
      acc_code = ERR_MISALIGNED;
    end else if (is_branch && !br_in_range) begin
      acc_code = ERR_BRANCH_RANGE;
    end else if (is_jump && !region_ok) begin
      acc_code = ERR_JUMP_REGION;
    end else begin
      acc_err = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    if (start_i) begin
      state_d    = ST_RUN;
      addr_d     = BASE_ADDR;
      count_d    = 9'd0;
      wr_valid_d = 1'b0;
      err_d      = 1'b0;
      err_code_d = ERR_ILLEGAL_OP;
    end else begin
      if (handshake) begin
        count_d    = count_q + 9'd1;
        wr_valid_d = 1'b0;
      end
      if (accept) begin
        if (acc_err) begin
          state_d    = ST_ERR;
          err_d      = 1'b1;
          err_code_d = acc_code;
        end else begin
          wr_valid_d = 1'b1;
          wr_addr_d  = addr_q;
          wr_data_d  = packed_word;
          addr_d     = next_pc;
          if (in_last_i) state_d = ST_DRAIN;
        end
      end else if (state_q == ST_DRAIN && (!wr_valid_q || handshake)) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= BASE_ADDR;
      count_q    <= 9'd0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 32'h0;
      wr_data_q  <= 32'h0;
      err_q      <= 1'b0;
      err_code_q <= ERR_ILLEGAL_OP;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign in_ready_o = in_ready;
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign count_o    = count_q;
  assign busy_o     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign full_o     = full;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;

endmodule

// File: tb/tb_mips_inst_encoder.sv
// Bench for mips_inst_encoder: directed vectors with literal expectations plus
// a cycle-by-cycle behavioural model compared on every clock.
module tb_mips_inst_encoder;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam int          MAXW = 4;

  logic        clk = 1'b0;
  logic        rst, start, inValid, inReady, inLast;
  logic [3:0]  inOp;
  logic [4:0]  inRs, inRt, inRd;
  logic [15:0] inImm;
  logic [31:0] inTarget;
  logic        wrValid, wrReady;
  logic [31:0] wrAddr, wrData;
  logic [8:0]  count;
  logic        busy, full, err;
  logic [1:0]  errCode;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state (0 idle, 1 run, 2 drain, 3 error).
  int          mState = 0;
  int          mCount = 0;
  bit          mPend = 0;
  logic [31:0] mPendAddr = 0, mPendData = 0, mNextA = BASE;
  bit          mErr = 0;
  logic [1:0]  mCode = 0;

  always #5 clk = ~clk;

  mips_inst_encoder #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .in_valid_i(inValid), .in_ready_o(inReady), .in_op_i(inOp),
    .in_rs_i(inRs), .in_rt_i(inRt), .in_rd_i(inRd), .in_imm_i(inImm),
    .in_target_i(inTarget), .in_last_i(inLast),
    .wr_valid_o(wrValid), .wr_ready_i(wrReady), .wr_addr_o(wrAddr), .wr_data_o(wrData),
    .count_o(count), .busy_o(busy), .full_o(full), .err_o(err), .err_code_o(errCode)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] opcodeOf(input logic [3:0] op);
    case (op)
      4'd4:  return 32'd8;
      4'd5:  return 32'd10;
      4'd6:  return 32'd35;
      4'd7:  return 32'd43;
      4'd8:  return 32'd2;
      4'd9:  return 32'd3;
      4'd10: return 32'd4;
      4'd11: return 32'd5;
      default: return 32'd0;
    endcase
  endfunction

  // Encoding rules written as field arithmetic rather than bit splicing.
  function automatic void modelEncode(input logic [3:0] op, input logic [4:0] rs, rt, rd,
                                      input logic [15:0] imm, input logic [31:0] target,
                                      input logic [31:0] a, output logic [31:0] word,
                                      output bit bad, output logic [1:0] code);
    logic [31:0] srcs;
    logic [31:0] opc;
    int d;
    srcs = 32'(rs) * 32'h0020_0000 + 32'(rt) * 32'h0001_0000;
    opc  = opcodeOf(op) * 32'h0400_0000;
    word = 32'h0;
    bad  = 1'b0;
    code = 2'd0;
    case (op)
      4'd0: word = srcs + 32'(rd) * 32'h800 + 32'd32;
      4'd1: word = srcs + 32'(rd) * 32'h800 + 32'd34;
      4'd2: word = srcs + 32'(rd) * 32'h800 + 32'd42;
      4'd3: word = 32'(rs) * 32'h0020_0000 + 32'd8;
      4'd4, 4'd5, 4'd6, 4'd7: word = opc + srcs + 32'(imm);
      4'd8, 4'd9: begin
        if (target % 4 != 0) begin bad = 1'b1; code = 2'd1; end
        else if (target / 32'h1000_0000 != (a + 4) / 32'h1000_0000) begin bad = 1'b1; code = 2'd3; end
        else word = opc + (target % 32'h1000_0000) / 4;
      end
      4'd10, 4'd11: begin
        if (target % 4 != 0) begin bad = 1'b1; code = 2'd1; end
        else begin
          d = int'(target - (a + 32'd4)) / 4;
          if (d < -32768 || d > 32767) begin bad = 1'b1; code = 2'd2; end
          else word = opc + srcs + 32'(d < 0 ? d + 65536 : d);
        end
      end
      4'd12: word = 32'h0;
      default: begin bad = 1'b1; code = 2'd0; end
    endcase
  endfunction

  function automatic bit modelFull();
    return (mCount + int'(mPend)) == MAXW;
  endfunction

  function automatic bit modelReady();
    return (mState == 1) && !modelFull() && (!mPend || wrReady);
  endfunction

  // Advance the model on every rising edge, then compare once the DUT settles.
  always @(posedge clk) begin : compare
    bit acc, hs, wasPend, bad;
    logic [31:0] w;
    logic [1:0]  c;
    if (rst) begin
      mState = 0; mCount = 0; mPend = 0; mErr = 0; mCode = 0; mNextA = BASE;
    end else if (start) begin
      mState = 1; mCount = 0; mPend = 0; mErr = 0; mCode = 0; mNextA = BASE;
    end else begin
      wasPend = mPend;
      acc = inValid && modelReady();
      hs  = mPend && wrReady;
      if (hs) begin mCount++; mPend = 0; end
      if (acc) begin
        modelEncode(inOp, inRs, inRt, inRd, inImm, inTarget, mNextA, w, bad, c);
        if (bad) begin
          mErr = 1; mCode = c; mState = 3;
        end else begin
          mPend = 1; mPendAddr = mNextA; mPendData = w; mNextA = mNextA + 32'd4;
          if (inLast) mState = 2;
        end
      end else if (mState == 2 && (!wasPend || hs)) begin
        mState = 0;
      end
    end
    #1;
    checkOutput("cyc in_ready", 32'(inReady), 32'(modelReady()));
    checkOutput("cyc wr_valid", 32'(wrValid), 32'(mPend));
    if (mPend) begin
      checkOutput("cyc wr_addr", wrAddr, mPendAddr);
      checkOutput("cyc wr_data", wrData, mPendData);
    end
    checkOutput("cyc count", 32'(count), 32'(mCount));
    checkOutput("cyc busy", 32'(busy), 32'(mState == 1 || mState == 2));
    checkOutput("cyc full", 32'(full), 32'(modelFull()));
    checkOutput("cyc err", 32'(err), 32'(mErr));
    checkOutput("cyc err_code", 32'(errCode), 32'(mCode));
  end

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one instruction at a falling edge and hold it until accepted.
  task automatic applyStimulus(input logic [3:0] op, input logic [4:0] rs, rt, rd,
                               input logic [15:0] imm, input logic [31:0] target, input logic last);
    int  waited = 0;
    bit  took = 0;
    inOp = op; inRs = rs; inRt = rt; inRd = rd; inImm = imm; inTarget = target; inLast = last;
    inValid = 1'b1;
    while (!took && waited < 20) begin
      #1;
      took = inReady;
      @(negedge clk);
      waited++;
    end
    inValid = 1'b0;
    inLast  = 1'b0;
    if (!took) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL accept timeout: op %0d not accepted within 20 cycles", op);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; inValid = 1'b0; inLast = 1'b0; wrReady = 1'b1;
    inOp = 0; inRs = 0; inRt = 0; inRd = 0; inImm = 0; inTarget = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset wr_valid", 32'(wrValid), 0);
    checkOutput("reset in_ready", 32'(inReady), 0);
    checkOutput("reset count", 32'(count), 0);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset full", 32'(full), 0);
    checkOutput("reset err", 32'(err), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] encodings and capacity");
    pulseStart();
    applyStimulus(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 1'b0);
    checkOutput("add addr", wrAddr, BASE);
    checkOutput("add data", wrData, 32'h0022_1820);
    applyStimulus(4'd6, 5'd9, 5'd8, 5'd0, 16'h0004, 32'h0, 1'b0);
    checkOutput("add count", 32'(count), 1);
    checkOutput("lw data", wrData, 32'h8D28_0004);
    applyStimulus(4'd11, 5'd1, 5'd2, 5'd0, 16'h0, BASE, 1'b0);
    checkOutput("bne back addr", wrAddr, BASE + 32'd8);
    checkOutput("bne back data", wrData, 32'h1422_FFFD);
    applyStimulus(4'd3, 5'd31, 5'd0, 5'd0, 16'h0, 32'h0, 1'b0);
    checkOutput("jr data", wrData, 32'h03E0_0008);
    checkOutput("full at max", 32'(full), 1);
    checkOutput("full in_ready", 32'(inReady), 0);
    @(negedge clk);
    checkOutput("full count", 32'(count), 4);

    $display("[TB] restart, branch and jump targets");
    pulseStart();
    checkOutput("restart count", 32'(count), 0);
    checkOutput("restart full", 32'(full), 0);
    applyStimulus(4'd10, 5'd1, 5'd2, 5'd0, 16'h0, BASE + 32'h10, 1'b0);
    checkOutput("beq fwd data", wrData, 32'h1022_0003);
    applyStimulus(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0040_0040, 1'b0);
    checkOutput("jal data", wrData, 32'h0C10_0010);
    applyStimulus(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 32'h1000_0000, 1'b0);
    checkOutput("jal region err", 32'(err), 1);
    checkOutput("jal region code", 32'(errCode), 3);
    checkOutput("jal region in_ready", 32'(inReady), 0);
    checkOutput("jal region no write", 32'(wrValid), 0);
    checkOutput("jal region count", 32'(count), 2);
    repeat (2) @(negedge clk);
    checkOutput("err sticky", 32'(err), 1);

    $display("[TB] remaining op encodings");
    pulseStart();
    applyStimulus(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 1'b0);
    checkOutput("sub data", wrData, 32'h0022_1822);
    applyStimulus(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 1'b0);
    checkOutput("slt data", wrData, 32'h0022_182A);
    applyStimulus(4'd4, 5'd1, 5'd2, 5'd0, 16'h1234, 32'h0, 1'b0);
    checkOutput("addi data", wrData, 32'h2022_1234);
    applyStimulus(4'd5, 5'd1, 5'd2, 5'd0, 16'h1234, 32'h0, 1'b0);
    checkOutput("slti data", wrData, 32'h2822_1234);
    pulseStart();
    applyStimulus(4'd7, 5'd9, 5'd8, 5'd0, 16'h0004, 32'h0, 1'b0);
    checkOutput("sw data", wrData, 32'hAD28_0004);
    applyStimulus(4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0040_0100, 1'b0);
    checkOutput("j data", wrData, 32'h0810_0040);
    applyStimulus(4'd12, 5'd7, 5'd7, 5'd7, 16'hFFFF, 32'h0, 1'b0);
    checkOutput("nop data", wrData, 32'h0);

    $display("[TB] branch range boundaries");
    pulseStart();
    applyStimulus(4'd10, 5'd1, 5'd2, 5'd0, 16'h0, 32'h003E_0004, 1'b0);
    checkOutput("beq min off", wrData, 32'h1022_8000);
    applyStimulus(4'd10, 5'd1, 5'd2, 5'd0, 16'h0, 32'h0042_0004, 1'b0);
    checkOutput("beq max off", wrData, 32'h1022_7FFF);
    applyStimulus(4'd10, 5'd1, 5'd2, 5'd0, 16'h0, 32'h0042_000C, 1'b0);
    checkOutput("beq over range code", 32'(errCode), 2);
    pulseStart();
    applyStimulus(4'd10, 5'd1, 5'd2, 5'd0, 16'h0, BASE + 32'h12, 1'b0);
    checkOutput("beq misaligned code", 32'(errCode), 1);
    checkOutput("beq misaligned err", 32'(err), 1);
    pulseStart();
    checkOutput("start clears err", 32'(err), 0);
    applyStimulus(4'd13, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 1'b0);
    checkOutput("illegal err", 32'(err), 1);
    checkOutput("illegal code", 32'(errCode), 0);
    checkOutput("illegal no write", 32'(wrValid), 0);

    $display("[TB] back-pressure and drain");
    pulseStart();
    applyStimulus(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 1'b0);
    wrReady = 1'b0;
    inOp = 4'd6; inRs = 5'd9; inRt = 5'd8; inImm = 16'h0004; inValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall data", wrData, 32'h0022_1820);
      checkOutput("stall addr", wrAddr, BASE);
      checkOutput("stall in_ready", 32'(inReady), 0);
      @(negedge clk);
    end
    wrReady = 1'b1;
    applyStimulus(4'd6, 5'd9, 5'd8, 5'd0, 16'h0004, 32'h0, 1'b0);
    checkOutput("stall word2 addr", wrAddr, BASE + 32'd4);
    applyStimulus(4'd3, 5'd31, 5'd0, 5'd0, 16'h0, 32'h0, 1'b1);
    checkOutput("last word addr", wrAddr, BASE + 32'd8);
    checkOutput("drain busy", 32'(busy), 1);
    @(negedge clk);
    checkOutput("drain idle", 32'(busy), 0);
    checkOutput("drain count", 32'(count), 3);
    checkOutput("drain wr_valid", 32'(wrValid), 0);

    $display("[TB] reset with a pending word");
    pulseStart();
    wrReady = 1'b0;
    applyStimulus(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 1'b0);
    checkOutput("pending before reset", 32'(wrValid), 1);
    rst = 1'b1;
    wrReady = 1'b1;
    @(negedge clk);
    checkOutput("reset drop wr_valid", 32'(wrValid), 0);
    checkOutput("reset drop count", 32'(count), 0);
    checkOutput("reset drop busy", 32'(busy), 0);
    checkOutput("reset drop in_ready", 32'(inReady), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mips_inst_encoder.md
# mips_inst_encoder

Sequential instruction encoder/loader for the single-cycle MIPS core: the inverse of the control-unit decode path. It accepts symbolic instructions (operation code plus register, immediate and absolute-target fields) over a valid/ready stream and assembles each into a 32-bit MIPS word. It resolves branch and jump targets against its own running address and writes the words sequentially into instruction memory through a valid/ready write port. It is used by the bench and boot path to load programs without a host-side assembler.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of the first word written after `start`
- MAX_WORDS, 256, capacity; `full` asserts when this many words have been written
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; clears count/error, address := BASE_ADDR, enters RUN
- in_valid / in_ready  input / output  1 / 1  instruction stream handshake
- in_op  input  4  0 add, 1 sub, 2 slt, 3 jr, 4 addi, 5 slti, 6 lw, 7 sw, 8 j, 9 jal, 10 beq, 11 bne, 12 nop; 13–15 illegal
- in_rs, in_rt, in_rd  input  5 each  register fields
- in_imm  input  16  immediate for addi/slti/lw/sw
- in_target  input  32  absolute byte target for beq/bne/j/jal
- in_last  input  1  final instruction of program
- wr_valid / wr_ready  output / input  1 / 1  memory write handshake
- wr_addr, wr_data  output  32 each  byte address and encoded word
- count  output  9  words written since `start`
- busy, full, err  output  1 each  status
- err_code  output  2  0 illegal op, 1 misaligned target, 2 branch out of range, 3 jump region mismatch

## Operation
- States: IDLE, RUN, DRAIN, ERR. Reset → IDLE; all outputs 0.
- IDLE: in_ready=0. `start` → RUN.
- RUN: in_ready = !full && (!wr_valid || wr_ready). On accept, the instruction address A = BASE_ADDR + 4·(words accepted so far).
- Encoding: R-type (add/sub/slt) {6'h00, rs, rt, rd, 5'b0, funct}; funct 0x20/0x22/0x2A. jr {6'h00, rs, 15'b0, 6'h08}. I-type {op, rs, rt, imm}; op addi 0x08, slti 0x0A, lw 0x23, sw 0x2B. nop = 32'h0.
- beq/bne (op 0x04/0x05): off = (in_target − (A+4)) >>> 2, signed; the in_target[1:0] check and the range check −32768 ≤ off ≤ 32767 use 32-bit signed arithmetic.
- j/jal (op 0x02/0x03): field = in_target[27:2]; requires in_target[31:28] == (A+4)[31:28].
- Errors detected at accept: the word is not written and count is unchanged. Transition to ERR, err=1, err_code latched, in_ready=0. Any already-pending word completes normally.
- in_last accepted without error → DRAIN; once the pending word is written → IDLE.
- `count` increments on each wr_valid&&wr_ready. `full` = (count + pending) == MAX_WORDS.
- ERR is sticky until `rst` or `start`.
- `start` in any state: drops any pending word (wr_valid→0), clears count/err/err_code, → RUN. `start` takes priority over a same-cycle input accept, which does not occur.
- `busy` = state ∈ {RUN, DRAIN}.

## Timing
- Latency accept → wr_valid: 1 cycle (registered output stage, depth 1). Throughput is 1 word/cycle when wr_ready is held high.
- wr_valid, wr_addr and wr_data hold stable while wr_valid && !wr_ready.
- in_ready is combinational from the state, `full`, wr_valid and wr_ready; it has no dependency on in_valid.
- Reset mid-operation: the pending word is dropped and no write handshake completes in the reset cycle.

## Structure
- Shared package mips_isa_pkg: opcode and funct constants (shared with the control unit), the in_op enumeration, err_code values, and the state enum.
- One combinational sub-module mips_field_pack: takes op, fields and resolved offset/target and produces the word plus an illegal flag. Address tracking, the range checks and the FSM stay in mips_inst_encoder.

## Test plan
- BASE 0, add rs=1 rt=2 rd=3 → wr_addr 0x0, wr_data 0x00221820, count=1 after the handshake.
- lw rs=9 rt=8 imm=4 → 0x8D280004. jr rs=31 → 0x03E00008.
- BASE 0, beq rs=1 rt=2 target 0x10 at A=0 → 0x10220003. bne at A=8 with target 0x0 → offset −3, imm 0xFFFD.
- BASE 0x00400000, jal target 0x00400040 → 0x0C100010. Same op with target 0x10000000 → no write, err=1, err_code=3, in_ready=0.
- Stream 3 words with wr_ready low for cycles 2–4 → word 1 held stable, in_ready=0, no loss or duplication; order and addresses 0/4/8 preserved. in_last on word 3 → IDLE after its write.
- MAX_WORDS=2 → full after 2 accepts with in_ready=0. Then `start` → count=0, full=0. beq target 0x12 → err_code=1. Assert `rst` with a word pending → wr_valid=0 on the next cycle and all outputs 0.
